// File: rtl/step_controller_if.sv
// -----------------------------------------------------------------------------
// step_controller_if
//    Byte stream from the UART receiver into the debug step controller, plus
//    the optional acknowledge channel back toward the UART transmitter.
//
//    Build option: STEP_ACK_EN -- when defined, the acknowledge signals
//    (ack_data / ack_valid / ack_ready) are part of the interface.
//
// Signals:
//    in_data    byte received from the UART (DATA_W bits)
//    in_valid   one-cycle strobe qualifying in_data
//    ack_data   acknowledge byte toward the transmitter   (STEP_ACK_EN only)
//    ack_valid  acknowledge pending                       (STEP_ACK_EN only)
//    ack_ready  transmitter accepts ack_data this cycle   (STEP_ACK_EN only)
//
// Modports:
//    master  command source (receiver / transmitter side)
//    slave   step controller
// -----------------------------------------------------------------------------
interface step_controller_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] in_data;
   logic              in_valid;

`ifdef STEP_ACK_EN
   logic [DATA_W-1:0] ack_data;
   logic              ack_valid;
   logic              ack_ready;

   modport master (output in_data, in_valid, ack_ready,
                   input  ack_data, ack_valid);
   modport slave  (input  in_data, in_valid, ack_ready,
                   output ack_data, ack_valid);
`else
   modport master (output in_data, in_valid);
   modport slave  (input  in_data, in_valid);
`endif
endinterface

// File: rtl/step_controller.sv
// -----------------------------------------------------------------------------
// step_controller
//    Debug step controller. Decodes command bytes from the UART receiver and
//    drives a registered single-cycle-accurate step enable into the pipeline.
//    Commands: single step, N-step burst (count in the following byte),
//    free run, halt. Keeps a wrapping count of cycles with step high.
//
//    Build option: STEP_ACK_EN -- when defined, every byte accepted in IDLE,
//    every count byte and every rejected in-flight byte produces an
//    acknowledge byte on the ack channel of the cmd interface.
//
// Ports:
//    clk         system clock, rising edge
//    rst_n       asynchronous active-low reset
//    cmd         step_controller_if.slave (in_data/in_valid, optional ack)
//    step        pipeline advance enable, registered
//    running     high while in RUN
//    busy        high in WAIT_CNT, BURST or RUN
//    err         one-cycle pulse for an unknown or rejected byte
//    step_total  count of cycles with step=1, wraps modulo 2^TOT_W
// -----------------------------------------------------------------------------
module step_controller #(
   parameter int                DATA_W    = 8,
   parameter int                CNT_W     = 8,
   parameter int                TOT_W     = 16,
   parameter logic [DATA_W-1:0] CMD_STEP  = 8'h73,
   parameter logic [DATA_W-1:0] CMD_MULTI = 8'h6E,
   parameter logic [DATA_W-1:0] CMD_RUN   = 8'h72,
   parameter logic [DATA_W-1:0] CMD_HALT  = 8'h68
) (
   input  logic                 clk,
   input  logic                 rst_n,
   step_controller_if.slave     cmd,
   output logic                 step,
   output logic                 running,
   output logic                 busy,
   output logic                 err,
   output logic [TOT_W-1:0]     step_total
);

   typedef enum logic [1:0] {IDLE, WAIT_CNT, BURST, RUN} state_t;

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  remaining_reg, remaining_next;
   logic              step_reg, step_next;
   logic              err_reg, err_next;
   logic              busy_reg, running_reg;
   logic [TOT_W-1:0]  total_reg;

   logic              is_halt;
   logic [CNT_W-1:0]  cnt_byte;

   assign is_halt  = (cmd.in_data == CMD_HALT);
   assign cnt_byte = cmd.in_data[CNT_W-1:0];

   // ---------------------------------------------------------------------------
   // Next-state / output decode. step_next is the value step will carry for the
   // whole cycle after the coming edge, which gives the one-cycle latency.
   // remaining counts pulses still owed including the one currently on step.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_next     = state_reg;
      remaining_next = remaining_reg;
      step_next      = 1'b0;
      err_next       = 1'b0;

      case (state_reg)
         IDLE: begin
            if (cmd.in_valid) begin
               if (cmd.in_data == CMD_STEP) begin
                  step_next = 1'b1;
               end else if (cmd.in_data == CMD_MULTI) begin
                  state_next = WAIT_CNT;
               end else if (cmd.in_data == CMD_RUN) begin
                  state_next = RUN;
                  step_next  = 1'b1;
               end else if (!is_halt) begin
                  err_next = 1'b1;
               end
            end
         end

         WAIT_CNT: begin
            if (cmd.in_valid) begin
               if (cnt_byte == '0) begin
                  state_next = IDLE;
               end else begin
                  state_next     = BURST;
                  remaining_next = cnt_byte;
                  step_next      = 1'b1;
               end
            end
         end

         BURST: begin
            if (cmd.in_valid && is_halt) begin
               state_next     = IDLE;
               remaining_next = '0;
            end else begin
               err_next       = cmd.in_valid;
               remaining_next = remaining_reg - CNT_W'(1);
               // The pulse on step right now is the last one owed.
               if (remaining_reg == CNT_W'(1)) begin
                  state_next = IDLE;
               end else begin
                  step_next = 1'b1;
               end
            end
         end

         RUN: begin
            if (cmd.in_valid && is_halt) begin
               state_next = IDLE;
            end else begin
               step_next = 1'b1;
               err_next  = cmd.in_valid;
            end
         end

         default: begin
            state_next     = IDLE;
            remaining_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         remaining_reg <= '0;
         step_reg      <= 1'b0;
         err_reg       <= 1'b0;
         busy_reg      <= 1'b0;
         running_reg   <= 1'b0;
         total_reg     <= '0;
      end else begin
         state_reg     <= state_next;
         remaining_reg <= remaining_next;
         step_reg      <= step_next;
         err_reg       <= err_next;
         busy_reg      <= (state_next != IDLE);
         running_reg   <= (state_next == RUN);
         // Counts the step cycle that is just ending.
         total_reg     <= total_reg + TOT_W'(step_reg);
      end
   end

   assign step       = step_reg;
   assign err        = err_reg;
   assign busy       = busy_reg;
   assign running    = running_reg;
   assign step_total = total_reg;

`ifdef STEP_ACK_EN
   localparam logic [DATA_W-1:0] ACK_UNKNOWN = DATA_W'(8'h3F);

   logic              ack_gen;
   logic [DATA_W-1:0] ack_byte;
   logic              known_cmd;
   logic              ack_valid_reg;
   logic [DATA_W-1:0] ack_data_reg;

   assign known_cmd = (cmd.in_data == CMD_STEP)  || (cmd.in_data == CMD_MULTI) ||
                      (cmd.in_data == CMD_RUN)   || is_halt;

   // Acked: anything in IDLE, the count byte, and rejected bytes while
   // stepping. A halt that ends a burst or run is not acknowledged.
   always_comb begin
      ack_gen  = 1'b0;
      ack_byte = cmd.in_data;
      case (state_reg)
         IDLE: begin
            ack_gen = cmd.in_valid;
            if (!known_cmd) ack_byte = ACK_UNKNOWN;
         end
         WAIT_CNT: ack_gen = cmd.in_valid;
         BURST, RUN: begin
            ack_gen  = cmd.in_valid && !is_halt;
            ack_byte = ACK_UNKNOWN;
         end
         default: ack_gen = 1'b0;
      endcase
   end

   // A pending ack is never overwritten; new acks arriving meanwhile
   // (including in the handshake cycle itself) are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_valid_reg <= 1'b0;
         ack_data_reg  <= '0;
      end else if (ack_valid_reg) begin
         if (cmd.ack_ready) ack_valid_reg <= 1'b0;
      end else if (ack_gen) begin
         ack_valid_reg <= 1'b1;
         ack_data_reg  <= ack_byte;
      end
   end

   assign cmd.ack_valid = ack_valid_reg;
   assign cmd.ack_data  = ack_data_reg;
`endif

endmodule

// File: tb/tb_step_controller.sv
// -----------------------------------------------------------------------------
// tb_step_controller
//    Self-checking bench for step_controller. A table of per-cycle vectors
//    {in_valid, in_data, expected step/err/busy/running} is driven on the
//    falling edge; the expected record goes into a scoreboard queue and is
//    popped and compared just after the following rising edge. step_total is
//    checked every cycle against a running sum of expected step cycles.
//    Hand-written sequences cover asynchronous reset mid-run and, when
//    STEP_ACK_EN is defined, the acknowledge channel.
// -----------------------------------------------------------------------------
module tb_step_controller;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        step, running, busy, err;
   logic [15:0] step_total;

   always #5 clk = ~clk;

   step_controller_if #(.DATA_W(8)) bus ();

   step_controller dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cmd        (bus),
      .step       (step),
      .running    (running),
      .busy       (busy),
      .err        (err),
      .step_total (step_total)
   );

   // exp bits: {step, err, busy, running}
   typedef struct {
      logic       v;
      logic [7:0] d;
      logic [3:0] exp;
      string      name;
   } vec_t;

   typedef struct {
      logic [3:0] exp;
      string      name;
   } sb_t;

   vec_t vecs[$];
   sb_t  sb[$];
   int   checks = 0;
   int   errors = 0;
   int   exp_total = 0;

   function automatic void add(input logic v, input logic [7:0] d,
                               input logic [3:0] e, input string nm);
      vec_t x;
      x.v = v; x.d = d; x.exp = e; x.name = nm;
      vecs.push_back(x);
   endfunction

   function automatic void add_n(input int n, input logic v, input logic [7:0] d,
                                 input logic [3:0] e, input string nm);
      for (int i = 0; i < n; i++) add(v, d, e, nm);
   endfunction

   task automatic check_cycle();
      sb_t        s;
      logic [3:0] got;
      s   = sb.pop_front();
      got = {step, err, busy, running};
      checks++;
      if (got !== s.exp) begin
         errors++;
         $display("FAIL %s: step/err/busy/run got %b want %b at %0t", s.name, got, s.exp, $time);
      end
      checks++;
      if (step_total !== exp_total[15:0]) begin
         errors++;
         $display("FAIL %s_total: step_total got %0d want %0d at %0t", s.name, step_total, exp_total, $time);
      end
      $display("cycle %-12s in_valid=%b in_data=%h out=%b step_total=%0d", s.name,
               bus.in_valid, bus.in_data, got, step_total);
      exp_total += int'(s.exp[3]);
   endtask

   task automatic drive(input logic v, input logic [7:0] d,
                        input logic [3:0] e, input string nm);
      sb_t s;
      @(negedge clk);
      bus.in_valid = v;
      bus.in_data  = d;
      s.exp  = e;
      s.name = nm;
      sb.push_back(s);
      @(posedge clk);
      #1;
      check_cycle();
   endtask

   task automatic check_bit(input string nm, input logic got, input logic want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %b want %b at %0t", nm, got, want, $time);
      end
   endtask

   task automatic check_byte(input string nm, input logic [15:0] got, input logic [15:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h want %h at %0t", nm, got, want, $time);
      end
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
`ifdef STEP_ACK_EN
      bus.ack_ready = 1'b0;
`endif

      // ---------------- table ----------------
      add(1, 8'h73, 4'b1000, "step1");
      add(0, 8'h73, 4'b0000, "step1_end");
      add_n(4, 0, 8'h73, 4'b0000, "hold");
      add(1, 8'h73, 4'b1000, "hold_strobe");
      add_n(5, 0, 8'h73, 4'b0000, "hold");
      add(1, 8'h73, 4'b1000, "b2b_a");
      add(1, 8'h73, 4'b1000, "b2b_b");
      add(0, 8'h00, 4'b0000, "b2b_end");
      add(1, 8'h6E, 4'b0010, "multi");
      add(1, 8'h05, 4'b1010, "cnt5");
      add_n(4, 0, 8'h05, 4'b1010, "burst5");
      add(0, 8'h00, 4'b0000, "burst5_end");
      add(1, 8'h6E, 4'b0010, "multi0");
      add(1, 8'h00, 4'b0000, "cnt0");
      add(0, 8'h00, 4'b0000, "cnt0_idle");
      add(1, 8'h6E, 4'b0010, "multiFF");
      add(1, 8'hFF, 4'b1010, "cntFF");
      add(1, 8'h73, 4'b1110, "burst_rej");
      add(0, 8'h00, 4'b1010, "burstFF");
      add(1, 8'h68, 4'b0000, "halt_burst");
      add(0, 8'h00, 4'b0000, "halt_idle1");
      add(1, 8'h6E, 4'b0010, "multi2");
      add(1, 8'h02, 4'b1010, "cnt2");
      add(0, 8'h00, 4'b1010, "burst2");
      add(1, 8'h68, 4'b0000, "halt_last");
      add(0, 8'h00, 4'b0000, "halt_idle2");
      add(1, 8'h72, 4'b1011, "run");
      add_n(3, 0, 8'h00, 4'b1011, "running");
      add(1, 8'h73, 4'b1111, "run_rej");
      add_n(19, 0, 8'h00, 4'b1011, "running");
      add(1, 8'h68, 4'b0000, "halt_run");
      add(0, 8'h00, 4'b0000, "run_idle");
      add(1, 8'h41, 4'b0100, "unknown");
      add(0, 8'h00, 4'b0000, "unk_idle");
      add(1, 8'h68, 4'b0000, "halt_noop");
      add(0, 8'h00, 4'b0000, "noop_idle");

      // ---------------- reset state ----------------
      repeat (3) @(posedge clk);
      #1;
      check_byte("reset_outs", {12'h000, step, err, busy, running}, 16'h0000);
      check_byte("reset_total", step_total, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) drive(vecs[i].v, vecs[i].d, vecs[i].exp, vecs[i].name);
      check_byte("total_after_table", step_total, 16'd38);

      // ---------------- asynchronous reset mid-run ----------------
      drive(1, 8'h72, 4'b1011, "run2");
      repeat (3) drive(0, 8'h00, 4'b1011, "running2");
      #2;
      rst_n = 1'b0;
      #1;
      check_byte("async_rst_outs", {13'h0000, step, busy, running}, 16'h0000);
      check_byte("async_rst_total", step_total, 16'h0000);
      exp_total = 0;
      @(negedge clk);
      rst_n = 1'b1;
      drive(0, 8'h00, 4'b0000, "post_rst");

`ifdef STEP_ACK_EN
      // ---------------- acknowledge channel ----------------
      check_bit("ack_valid_rst", bus.ack_valid, 1'b0);
      drive(1, 8'h73, 4'b1000, "ack_step");
      check_bit("ack_valid_rise", bus.ack_valid, 1'b1);
      check_byte("ack_data_step", {8'h00, bus.ack_data}, 16'h0073);
      drive(1, 8'h41, 4'b0100, "ack_unk");
      check_byte("ack_hold1", {8'h00, bus.ack_data}, 16'h0073);
      repeat (3) drive(0, 8'h00, 4'b0000, "ack_wait");
      check_bit("ack_valid_held", bus.ack_valid, 1'b1);
      check_byte("ack_hold2", {8'h00, bus.ack_data}, 16'h0073);
      @(negedge clk);
      bus.ack_ready = 1'b1;
      @(posedge clk);
      #1;
      check_bit("ack_valid_drop", bus.ack_valid, 1'b0);
      @(negedge clk);
      bus.ack_ready = 1'b0;
      drive(0, 8'h00, 4'b0000, "ack_after");
      check_bit("ack_no_replay", bus.ack_valid, 1'b0);
      drive(1, 8'h6E, 4'b0010, "ack_multi");
      check_byte("ack_data_multi", {7'h00, bus.ack_valid, bus.ack_data}, 16'h016E);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
